// File: rtl/vga_frame_receiver_if.sv
// ---------------------------------------------------------------------------
// vga_frame_receiver_if
// Bundles the video input stream and the receiver's result signals.
//   pixel_en                    pixel-rate strobe
//   H_SyncIn, V_SyncIn          active-low syncs
//   RedIn, GreenIn, BlueIn      8-bit colour components
//   pixel_valid/x/y/rgb         captured pixel (registered)
//   locked, frame_done,
//   timing_error                receiver status
//   frame_checksum              checksum of the last completed frame
// Modports: master = video source / consumer side, slave = receiver.
// ---------------------------------------------------------------------------
interface vga_frame_receiver_if;
  logic        pixel_en;
  logic        H_SyncIn;
  logic        V_SyncIn;
  logic [7:0]  RedIn;
  logic [7:0]  GreenIn;
  logic [7:0]  BlueIn;
  logic        pixel_valid;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [23:0] pixel_rgb;
  logic        locked;
  logic        frame_done;
  logic        timing_error;
  logic [31:0] frame_checksum;

  modport master (
    output pixel_en, H_SyncIn, V_SyncIn, RedIn, GreenIn, BlueIn,
    input  pixel_valid, pixel_x, pixel_y, pixel_rgb,
    input  locked, frame_done, timing_error, frame_checksum
  );

  modport slave (
    input  pixel_en, H_SyncIn, V_SyncIn, RedIn, GreenIn, BlueIn,
    output pixel_valid, pixel_x, pixel_y, pixel_rgb,
    output locked, frame_done, timing_error, frame_checksum
  );
endinterface

// File: rtl/vga_frame_receiver.sv
// ---------------------------------------------------------------------------
// vga_frame_receiver
// Measures incoming VGA timing, locks once one whole frame has been seen
// with correct line and frame lengths, and then captures active pixels with
// their coordinates.
// Ports:
//   clk    system clock, everything on the rising edge
//   reset  asynchronous active-high reset
//   vif    vga_frame_receiver_if.slave (video input + status/pixel outputs)
// Optional feature: define VGA_RX_CHECKSUM_EN to build the per-frame
// checksum; otherwise frame_checksum is tied to 0.
// ---------------------------------------------------------------------------
module vga_frame_receiver #(
  parameter int H_ACTIVE = 640,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_TOTAL  = 800,
  parameter int V_ACTIVE = 480,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_TOTAL  = 525
) (
  input logic                 clk,
  input logic                 reset,
  vga_frame_receiver_if.slave vif
);

  // Counters are wider than any legal timing so a missing sync saturates
  // instead of wrapping back onto a value that would pass the checks.
  localparam int CW = 16;
  localparam logic [CW-1:0] H_START   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_END     = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_START   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_END     = CW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [CW:0]   H_TOTAL_W = (CW+1)'(H_TOTAL);
  localparam logic [CW:0]   V_TOTAL_W = (CW+1)'(V_TOTAL);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t        state_reg, state_next;
  logic          prev_hs_reg, prev_vs_reg;
  logic [CW-1:0] h_cnt_reg, v_cnt_reg;
  logic [CW-1:0] h_next, v_next;
  logic          skip_line_reg, skip_line_next;
  logic          meas_err_reg, meas_err_next;
  logic          pixel_valid_reg;
  logic [9:0]    pixel_x_reg, pixel_y_reg;
  logic [23:0]   pixel_rgb_reg, pixel_rgb_next;
  logic          frame_done_reg, frame_done_next;
  logic          timing_error_reg, timing_error_next;

  logic hs_edge, vs_edge, line_err, frame_err, active;

  // Previous-sample registers reset to 0, so the first sample after reset
  // can never be mistaken for a falling edge.
  assign hs_edge = vif.pixel_en & prev_hs_reg & ~vif.H_SyncIn;
  assign vs_edge = vif.pixel_en & prev_vs_reg & ~vif.V_SyncIn;

  assign pixel_rgb_next = {vif.RedIn, vif.GreenIn, vif.BlueIn};

  // h_next/v_next are the coordinates of the pixel being sampled now.
  always_comb begin
    h_next = h_cnt_reg;
    v_next = v_cnt_reg;
    if (vif.pixel_en) begin
      if (hs_edge)
        h_next = '0;
      else if (h_cnt_reg != '1)
        h_next = h_cnt_reg + 1'b1;

      if (vs_edge)
        v_next = '0;
      else if (hs_edge && (v_cnt_reg != '1))
        v_next = v_cnt_reg + 1'b1;
    end
  end

  // The line length is the old count plus the edge sample itself; the frame
  // length includes an hsync edge coinciding with the vsync edge.
  assign line_err  = hs_edge & ~skip_line_reg &
                     (({1'b0, h_cnt_reg} + (CW+1)'(1)) != H_TOTAL_W);
  assign frame_err = vs_edge &
                     (({1'b0, v_cnt_reg} + {{CW{1'b0}}, hs_edge}) != V_TOTAL_W);

  assign active = vif.pixel_en && (state_reg == LOCKED) &&
                  (h_next >= H_START) && (h_next <= H_END) &&
                  (v_next >= V_START) && (v_next <= V_END);

  always_comb begin
    state_next        = state_reg;
    meas_err_next     = meas_err_reg;
    skip_line_next    = skip_line_reg;
    frame_done_next   = 1'b0;
    timing_error_next = 1'b0;

    if (hs_edge)
      skip_line_next = 1'b0;

    case (state_reg)
      SEARCH: begin
        if (vs_edge) begin
          state_next    = MEASURE;
          meas_err_next = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_edge) begin
          if (meas_err_reg || line_err || frame_err) begin
            // Failed window: report it and start a fresh measurement.
            timing_error_next = 1'b1;
            meas_err_next     = 1'b0;
          end else begin
            state_next = LOCKED;
          end
        end else if (line_err) begin
          meas_err_next = 1'b1;
        end
      end
      LOCKED: begin
        if (line_err || frame_err) begin
          timing_error_next = 1'b1;
          state_next        = SEARCH;
          // The line in progress is of unknown length: do not judge it.
          skip_line_next    = 1'b1;
        end else if (vs_edge) begin
          frame_done_next = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= SEARCH;
      prev_hs_reg      <= 1'b0;
      prev_vs_reg      <= 1'b0;
      h_cnt_reg        <= '0;
      v_cnt_reg        <= '0;
      skip_line_reg    <= 1'b1;
      meas_err_reg     <= 1'b0;
      pixel_valid_reg  <= 1'b0;
      pixel_x_reg      <= '0;
      pixel_y_reg      <= '0;
      pixel_rgb_reg    <= '0;
      frame_done_reg   <= 1'b0;
      timing_error_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      skip_line_reg    <= skip_line_next;
      meas_err_reg     <= meas_err_next;
      h_cnt_reg        <= h_next;
      v_cnt_reg        <= v_next;
      if (vif.pixel_en) begin
        prev_hs_reg <= vif.H_SyncIn;
        prev_vs_reg <= vif.V_SyncIn;
      end
      pixel_valid_reg <= active;
      if (active) begin
        pixel_x_reg   <= 10'(h_next - H_START);
        pixel_y_reg   <= 10'(v_next - V_START);
        pixel_rgb_reg <= pixel_rgb_next;
      end
      frame_done_reg   <= frame_done_next;
      timing_error_reg <= timing_error_next;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [31:0] acc_reg;
  logic [31:0] checksum_reg;

  // The vsync-edge sample is never active, so clearing there loses nothing;
  // the finished frame's sum is captured from the old accumulator value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg      <= '0;
      checksum_reg <= '0;
    end else begin
      if (vs_edge)
        acc_reg <= '0;
      else if (active)
        acc_reg <= acc_reg + {8'h00, pixel_rgb_next};
      if (frame_done_next)
        checksum_reg <= acc_reg;
    end
  end

  assign vif.frame_checksum = checksum_reg;
`else
  assign vif.frame_checksum = '0;
`endif

  assign vif.pixel_valid  = pixel_valid_reg;
  assign vif.pixel_x      = pixel_x_reg;
  assign vif.pixel_y      = pixel_y_reg;
  assign vif.pixel_rgb    = pixel_rgb_reg;
  assign vif.locked       = (state_reg == LOCKED);
  assign vif.frame_done   = frame_done_reg;
  assign vif.timing_error = timing_error_reg;

endmodule

// File: tb/tb_vga_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_vga_frame_receiver
// Drives a scaled-down VGA timing (16x12 total, 8x6 active) through the
// receiver. A frame-level table states the expected status pulses per frame;
// an index-based reference model predicts every output on every clock.
// ---------------------------------------------------------------------------
module tb_vga_frame_receiver;
  localparam int HA = 8, HS = 2, HB = 2, HT = 16;
  localparam int VA = 6, VS = 1, VB = 2, VT = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_frame_receiver_if vif();

  vga_frame_receiver #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .vif  (vif)
  );

  int checks = 0;
  int failures = 0;
  int te_seen = 0;
  int fd_seen = 0;

  // Reference model state: positions come from sample indices.
  int  m_n, m_last_hs, m_lines, m_mode;   // mode 0 search, 1 measure, 2 locked
  bit  m_have_prev, m_prev_hs, m_prev_vs, m_check_line, m_bad;
  logic [31:0] m_acc;
  bit  e_valid, e_locked, e_fd, e_te;
  int  e_x, e_y;
  logic [23:0] e_rgb;
  logic [31:0] e_ck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_last_hs = -1; m_lines = 0; m_mode = 0;
    m_have_prev = 0; m_prev_hs = 0; m_prev_vs = 0; m_check_line = 0; m_bad = 0;
    m_acc = 0;
    e_valid = 0; e_locked = 0; e_fd = 0; e_te = 0; e_x = 0; e_y = 0; e_rgb = 0; e_ck = 0;
  endtask

  task automatic model_step(input bit en, input bit hs, input bit vs, input logic [23:0] rgb);
    bit hse, vse, lbad, fbad, act;
    int h, v;
    e_valid = 0; e_fd = 0; e_te = 0;
    if (en) begin
      hse = m_have_prev && m_prev_hs && !hs;
      vse = m_have_prev && m_prev_vs && !vs;
      m_have_prev = 1; m_prev_hs = hs; m_prev_vs = vs;
      lbad = hse && m_check_line && ((m_n - m_last_hs) != HT);
      fbad = vse && ((m_lines + (hse ? 1 : 0)) != VT);
      if (hse) begin
        m_last_hs = m_n;
        m_check_line = 1;
      end
      if (vse) m_lines = 0;
      else if (hse) m_lines++;
      h = m_n - m_last_hs;
      v = m_lines;
      act = (m_mode == 2) && h >= HS + HB && h < HS + HB + HA && v >= VS + VB && v < VS + VB + VA;
      case (m_mode)
        0: if (vse) begin m_mode = 1; m_bad = 0; end
        1: begin
          if (vse) begin
            if (m_bad || lbad || fbad) begin e_te = 1; m_bad = 0; end
            else m_mode = 2;
          end else if (lbad) m_bad = 1;
        end
        default: begin
          if (lbad || fbad) begin e_te = 1; m_mode = 0; m_check_line = 0; end
          else if (vse) e_fd = 1;
        end
      endcase
`ifdef VGA_RX_CHECKSUM_EN
      if (e_fd) e_ck = m_acc;
      if (act) m_acc = m_acc + {8'h00, rgb};
      if (vse) m_acc = 0;
`endif
      if (act) begin
        e_valid = 1; e_x = h - (HS + HB); e_y = v - (VS + VB); e_rgb = rgb;
      end
      e_locked = (m_mode == 2);
      m_n++;
    end
  endtask

  task automatic cycle(input bit en, input bit hs, input bit vs, input logic [23:0] rgb);
    vif.pixel_en = en; vif.H_SyncIn = hs; vif.V_SyncIn = vs;
    vif.RedIn = rgb[23:16]; vif.GreenIn = rgb[15:8]; vif.BlueIn = rgb[7:0];
    @(posedge clk); #1;
    model_step(en, hs, vs, rgb);
    check("pixel_valid", 32'(vif.pixel_valid), 32'(e_valid));
    check("pixel_x", 32'(vif.pixel_x), e_x);
    check("pixel_y", 32'(vif.pixel_y), e_y);
    check("pixel_rgb", 32'(vif.pixel_rgb), 32'(e_rgb));
    check("locked", 32'(vif.locked), 32'(e_locked));
    check("frame_done", 32'(vif.frame_done), 32'(e_fd));
    check("timing_error", 32'(vif.timing_error), 32'(e_te));
    check("frame_checksum", vif.frame_checksum, e_ck);
    te_seen += int'(vif.timing_error);
    fd_seen += int'(vif.frame_done);
  endtask

  task automatic gaps(input bit hs, input bit vs);
    repeat ($urandom_range(1, 2)) cycle(1'b0, hs, vs, 24'($urandom));
  endtask

  // rgb_mode: 0 random, 1 constant 0x000001, 2 random with a marker pixel
  // at the first active position.
  task automatic send_frame(input int nlines, input int short_line, input int short_len,
                            input int rgb_mode, input int stop_line);
    for (int l = 0; l < nlines && l < stop_line; l++) begin
      int len;
      len = (l == short_line) ? short_len : HT;
      for (int c = 0; c < len; c++) begin
        bit hs, vs, mark;
        logic [23:0] rgb;
        hs = (c >= HS);
        vs = (l >= VS);
        mark = (rgb_mode == 2) && (l == VS + VB) && (c == HS + HB);
        rgb = (rgb_mode == 1) ? 24'h000001 : 24'($urandom);
        if (mark) rgb = 24'h123456;
        cycle(1'b1, hs, vs, rgb);
        if (mark) begin
          check("marker_valid", 32'(vif.pixel_valid), 32'd1);
          check("marker_x", 32'(vif.pixel_x), 32'd0);
          check("marker_y", 32'(vif.pixel_y), 32'd0);
          check("marker_rgb", 32'(vif.pixel_rgb), 32'h123456);
        end
        gaps(hs, vs);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 24'($urandom));
      gaps(1'b1, 1'b1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(vif.pixel_valid), 32'd0);
    check({tag, "_x"}, 32'(vif.pixel_x), 32'd0);
    check({tag, "_y"}, 32'(vif.pixel_y), 32'd0);
    check({tag, "_rgb"}, 32'(vif.pixel_rgb), 32'd0);
    check({tag, "_locked"}, 32'(vif.locked), 32'd0);
    check({tag, "_done"}, 32'(vif.frame_done), 32'd0);
    check({tag, "_terr"}, 32'(vif.timing_error), 32'd0);
    check({tag, "_cksum"}, vif.frame_checksum, 32'd0);
  endtask

  typedef struct {
    int nlines;
    int short_line;
    int short_len;
    int rgb_mode;
    int exp_te;      // timing_error pulses seen while this frame is sent
    int exp_fd;      // frame_done pulses seen while this frame is sent
    bit exp_locked;  // locked at the end of this frame
  } rec_t;

  rec_t tbl[14];
  logic [31:0] exp_sum;

  initial begin
    // The pulses caused by a frame's closing vsync appear at the start of
    // the following record.
    tbl[0]  = '{12, -1, 0, 0, 0, 0, 1'b0};  // SEARCH -> MEASURE
    tbl[1]  = '{12, -1, 0, 0, 0, 0, 1'b1};  // MEASURE -> LOCKED
    tbl[2]  = '{12, -1, 0, 0, 0, 1, 1'b1};
    tbl[3]  = '{12,  5, 15, 0, 1, 1, 1'b0}; // short line while locked
    tbl[4]  = '{12, -1, 0, 0, 0, 0, 1'b0};
    tbl[5]  = '{12, -1, 0, 0, 0, 0, 1'b1};  // relocked after two vsyncs
    tbl[6]  = '{12, -1, 0, 0, 0, 1, 1'b1};
    tbl[7]  = '{11, -1, 0, 0, 0, 1, 1'b1};  // short frame while locked
    tbl[8]  = '{12, -1, 0, 0, 1, 0, 1'b0};
    tbl[9]  = '{11, -1, 0, 0, 0, 0, 1'b0};  // short frame during MEASURE
    tbl[10] = '{12, -1, 0, 0, 1, 0, 1'b0};  // measure fails, stays MEASURE
    tbl[11] = '{12, -1, 0, 1, 0, 0, 1'b1};
    tbl[12] = '{12, -1, 0, 1, 0, 1, 1'b1};
    tbl[13] = '{12, -1, 0, 2, 0, 1, 1'b1};  // marker pixel

    vif.pixel_en = 0; vif.H_SyncIn = 1; vif.V_SyncIn = 1;
    vif.RedIn = 0; vif.GreenIn = 0; vif.BlueIn = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    model_reset();
    idle(4);

    for (int r = 0; r < 14; r++) begin
      te_seen = 0;
      fd_seen = 0;
      send_frame(tbl[r].nlines, tbl[r].short_line, tbl[r].short_len, tbl[r].rgb_mode, 1000);
      check($sformatf("rec%0d_terr_count", r), te_seen, tbl[r].exp_te);
      check($sformatf("rec%0d_done_count", r), fd_seen, tbl[r].exp_fd);
      check($sformatf("rec%0d_locked", r), 32'(vif.locked), 32'(tbl[r].exp_locked));
    end

`ifdef VGA_RX_CHECKSUM_EN
    exp_sum = HA * VA;
`else
    exp_sum = 0;
`endif
    check("checksum_const_frame", vif.frame_checksum, exp_sum);

    // Asynchronous reset in the middle of a locked frame.
    send_frame(VT, -1, 0, 0, 6);
    #2 reset = 1'b1;
    #1;
    check_all_zero("midreset");
    vif.pixel_en = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    idle(3);
    te_seen = 0; fd_seen = 0;
    send_frame(VT, -1, 0, 0, 1000);
    send_frame(VT, -1, 0, 0, 1000);
    check("postreset_no_done", fd_seen, 0);
    check("postreset_locked", 32'(vif.locked), 32'd1);
    fd_seen = 0;
    send_frame(VT, -1, 0, 0, 1000);
    check("postreset_first_done", fd_seen, 1);
    check("postreset_no_terr", te_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vga_frame_receiver.md
VGA_FRAME_RECEIVER -- requirements
Module: vga_frame_receiver

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_SYNC, 96 / H_BP, 48 / H_TOTAL, 800: hsync width, back porch and total line length, in pixels.
REQ-003 Parameter V_ACTIVE, 480 / V_SYNC, 2 / V_BP, 33 / V_TOTAL, 525: vsync width, back porch and total frame length, in lines.
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pixel_en  input  1  pixel-rate strobe; inputs are sampled only on cycles where it is 1.
REQ-007 H_SyncIn, V_SyncIn  input  1 each  syncs, active-low, synchronous to clk.
REQ-008 RedIn, GreenIn, BlueIn  input  8 each  pixel colour.
REQ-009 pixel_valid  output  1  registered; current pixel outputs are in the active area.
REQ-010 pixel_x  output  10  / pixel_y  output  10  pixel coordinates.
REQ-011 pixel_rgb  output  24  {R,G,B} of the captured pixel.
REQ-012 locked  output  1  timing verified; receiver in LOCKED.
REQ-013 frame_done  output  1  one-clk pulse at the end of each locked frame.
REQ-014 timing_error  output  1  one-clk pulse on a line-length or frame-length violation.
REQ-015 frame_checksum  output  32  checksum of the last completed frame.

Function
REQ-016 A sync edge is a 1->0 transition between consecutive pixel_en samples.
REQ-017 h_cnt is cleared to 0 on an hsync edge and increments on every other pixel_en sample.
REQ-018 v_cnt is cleared to 0 on a vsync edge and increments on each hsync edge.
REQ-019 When hsync and vsync edges coincide, v_cnt is cleared to 0.
REQ-020 Line check: on each hsync edge, h_cnt+1 is compared to H_TOTAL; a mismatch is a line error.
REQ-021 The line check is skipped for the first hsync edge after reset or after entering SEARCH.
REQ-022 Frame check: on each vsync edge, the number of hsync edges since the previous vsync edge is compared to V_TOTAL, counting a coincident edge; a mismatch is a frame error.
REQ-023 States are SEARCH, MEASURE and LOCKED.
REQ-024 SEARCH -> MEASURE on a vsync edge.
REQ-025 In MEASURE, the first vsync edge with no line or frame errors since entry -> LOCKED; otherwise timing_error pulses and the state stays MEASURE.
REQ-026 In LOCKED, any line or frame error pulses timing_error, deasserts locked and -> SEARCH in the same cycle.
REQ-027 locked = 1 only in LOCKED.
REQ-028 Active pixel: in LOCKED, h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
REQ-029 For an active pixel, pixel_x = h_cnt-(H_SYNC+H_BP) and pixel_y = v_cnt-(V_SYNC+V_BP).
REQ-030 Latency: one clk from the pixel_en sample to pixel_valid, pixel_x, pixel_y and pixel_rgb.
REQ-031 pixel_valid is 0 on all non-pixel_en cycles; the other pixel outputs hold their values.
REQ-032 frame_done pulses on a vsync edge in LOCKED that passes the frame check; it does not pulse on the MEASURE->LOCKED transition.
REQ-033 pixel_en low for any number of cycles freezes all counters and state.

Reset
REQ-034 Reset asserted at any time, including mid-frame, forces within the same cycle: state SEARCH, all counters 0, every output 0, checksum accumulator 0.
REQ-035 After reset release, lock requires a fresh MEASURE frame.

Configuration
REQ-036 Macro VGA_RX_CHECKSUM_EN compiles in the frame checksum.
REQ-037 With the macro defined:
- an accumulator adds the zero-extended {R,G,B} of every active pixel, mod 2^32;
- the accumulator clears on every vsync edge;
- the accumulated value is latched into frame_checksum in the same cycle frame_done pulses.
REQ-038 Without the macro, frame_checksum is constant 0 and no accumulator exists.

Verification
REQ-039 Two ideal 640x480 frames with pixel_en every 2nd clk -> locked rises at the 2nd vsync edge; timing_error never pulses.
REQ-040 Locked frame where the pixel at h_cnt=144, v_cnt=35 is 0x123456 -> one clk later pixel_valid=1, pixel_x=0, pixel_y=0, pixel_rgb=0x123456.
REQ-041 One line shortened to 799 pixels while LOCKED -> timing_error pulses at that hsync edge; locked=0 at the next clk; relock takes two more good frames.
REQ-042 VGA_RX_CHECKSUM_EN defined, every active pixel 0x000001 -> frame_done pulses; frame_checksum=307200.
REQ-043 Reset asserted at v_cnt=200 of a locked frame -> all outputs 0 immediately; no frame_done until a full MEASURE frame plus one locked frame complete.
REQ-044 Frame of 524 lines while in MEASURE -> timing_error pulses; state stays MEASURE; locked=0.
